// File: rtl/mul_pkg.sv
// Shared types for the sequential Booth multiplier: op encoding, FSM states and digit count.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_t;

  // Operands are widened by two bits, so each radix-4 digit covers two of them.
  function automatic int digit_count(input int xlen);
    return (xlen + 2) / 2;
  endfunction

endpackage

// File: rtl/booth_digit_sel.sv
// Radix-4 Booth digit selector: maps a 3-bit window to 0, +/-A or +/-2A at double width.
module booth_digit_sel #(
  parameter int W = 34
) (
  input  logic        [2:0]   win,
  input  logic signed [W-1:0] a,
  output logic signed [2*W-1:0] mult
);

  logic signed [2*W-1:0] a_ext;

  assign a_ext = {{W{a[W-1]}}, a};

  always_comb begin
    mult = '0;
    unique case (win)
      3'b001, 3'b010: mult = a_ext;
      3'b011:         mult = a_ext <<< 1;
      3'b100:         mult = -(a_ext <<< 1);
      3'b101, 3'b110: mult = -a_ext;
      default:        mult = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Iterative radix-4 Booth multiplier for MUL/MULH/MULHSU/MULHU, one digit per clock,
// valid/ready request and response handshakes, zero-operand early-out and flush.
module booth_seq_multiplier
  import mul_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data
);

  localparam int W  = XLEN + 2;
  localparam int N  = digit_count(XLEN);
  localparam int CW = $clog2(N + 1);

  mul_state_t            state_q, state_d;
  mul_op_t               op_q, op_d;
  logic signed [W-1:0]   a_q, a_d;
  logic signed [W-1:0]   m_q, m_d;
  logic                  mprev_q, mprev_d;
  logic signed [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]       resp_data_q, resp_data_d;

  mul_op_t               req_op_t;
  logic                  req_zero;
  logic signed [2*W-1:0] mult;
  logic [CW:0]           shamt;

  function automatic logic signed [W-1:0] extend(input logic [XLEN-1:0] x, input logic sgn);
    return {{2{sgn & x[XLEN-1]}}, x};
  endfunction

  assign req_op_t = mul_op_t'(req_op);
  assign req_zero = (req_rs1 == '0) || (req_rs2 == '0);
  assign shamt    = {cnt_q, 1'b0};

  booth_digit_sel #(.W(W)) u_digit_sel (
    .win  ({m_q[1], m_q[0], mprev_q}),
    .a    (a_q),
    .mult (mult)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    m_d          = m_q;
    mprev_d      = mprev_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;

    if (flush) begin
      state_d      = IDLE;
      resp_valid_d = 1'b0;
      resp_data_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_d    = req_op_t;
            a_d     = extend(req_rs1, req_op_t != MULHU);
            m_d     = extend(req_rs2, (req_op_t == MUL) || (req_op_t == MULH));
            mprev_d = 1'b0;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = (EARLY_OUT && req_zero) ? DONE : BUSY;
          end
        end
        BUSY: begin
          acc_d   = acc_q + (mult <<< shamt);
          m_d     = m_q >>> 2;
          mprev_d = m_q[1];
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) state_d = DONE;
        end
        DONE: begin
          // First DONE cycle publishes the product; the accumulator is already final.
          if (!resp_valid_q) begin
            resp_valid_d = 1'b1;
            resp_data_d  = (op_q == MUL) ? acc_q[XLEN-1:0] : acc_q[2*XLEN-1:XLEN];
          end else if (resp_ready) begin
            resp_valid_d = 1'b0;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= MUL;
      a_q          <= '0;
      m_q          <= '0;
      mprev_q      <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      m_q          <= m_d;
      mprev_q      <= mprev_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

endmodule
